tribus_receiver: RTL and testbench

- Receive-side controller for a shared tristate bus whose drivers are bufif1-style enable buffers (INP/ENB -> Z).
- Issues one-hot active-high enables to N drivers in round-robin order and samples the bus after a settle period.
- Inserts a turnaround gap with all enables low so two drivers never overlap.
- Presents captured words on a valid/ready output with source index; flags floating (Z/X) bits at sample time.

---
 rtl/tribus_receiver.sv | 164 ++++++++++++++++
 tb/tb_tribus_receiver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tribus_receiver.sv
// Receive-side controller for a shared tristate bus built from enable buffers.
// Grants one driver at a time in round-robin order, holds its enable for a
// settle period, samples the bus, then idles all enables for a turnaround gap.
//
// Ports:
//   CLK        clock, rising edge
//   RSTB       asynchronous active-low reset
//   REQ[N]     per-driver request (level, sampled only while idle)
//   ENB[N]     one-hot driver enable
//   BUS[W]     resolved tristate bus
//   DOUT[W]    captured word
//   DSRC[SW]   index of the driver that produced DOUT
//   DVALID     DOUT/DSRC valid
//   DREADY     consumer accepts DOUT
//   FLOAT_ERR  one-cycle pulse when the captured word had floating bits
module tribus_receiver #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned TURN   = 1,
    localparam int unsigned SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  ENB,
    input  logic [W-1:0]  BUS,
    output logic [W-1:0]  DOUT,
    output logic [SW-1:0] DSRC,
    output logic          DVALID,
    input  logic          DREADY,
    output logic          FLOAT_ERR
);

    localparam int unsigned CMAX = (SETTLE > TURN) ? SETTLE : TURN;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t         state, state_n;
    logic [SW-1:0]  ptr, ptr_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N-1:0]   enb_n;
    logic [W-1:0]   dout_n;
    logic [SW-1:0]  dsrc_n;
    logic           dvalid_n;
    logic           ferr_n;

    logic           pick_found;
    logic [SW-1:0]  pick_idx;
    logic [W-1:0]   keep_word;
    logic           keep_float;
    logic           buf_free;

    // Output buffer can take a new word if empty or being drained this cycle.
    assign buf_free = !DVALID || DREADY;

    // Round-robin search: first requester strictly after the last grant.
    always_comb begin
        logic [SW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = SW'((32'(ptr) + k) % N);
            if (!pick_found && REQ[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Bus-keeper merge: non-0/1 bits keep the previous DOUT value.
    always_comb begin
        keep_word  = DOUT;
        keep_float = 1'b0;
        for (int b = 0; b < int'(W); b++) begin
            if ((BUS[b] !== 1'b0) && (BUS[b] !== 1'b1)) begin
                keep_float = 1'b1;
            end else begin
                keep_word[b] = BUS[b];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        enb_n    = ENB;
        dout_n   = DOUT;
        dsrc_n   = DSRC;
        dvalid_n = DVALID && !DREADY;
        ferr_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (pick_found && buf_free) begin
                    enb_n   = N'(1) << pick_idx;
                    ptr_n   = pick_idx;
                    cnt_n   = CW'(SETTLE);
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (cnt == CW'(1)) begin
                    dout_n   = keep_word;
                    dsrc_n   = ptr;
                    dvalid_n = 1'b1;
                    ferr_n   = keep_float;
                    enb_n    = '0;
                    if (TURN == 0) begin
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = CW'(TURN);
                        state_n = S_TURN;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_TURN: begin
                if (cnt == CW'(1)) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                enb_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops ENB without a clock.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= S_IDLE;
            ptr       <= SW'(N - 1);
            cnt       <= '0;
            ENB       <= '0;
            DOUT      <= '0;
            DSRC      <= '0;
            DVALID    <= 1'b0;
            FLOAT_ERR <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            ENB       <= enb_n;
            DOUT      <= dout_n;
            DSRC      <= dsrc_n;
            DVALID    <= dvalid_n;
            FLOAT_ERR <= ferr_n;
        end
    end

endmodule

// File: tb/tb_tribus_receiver.sv
// Self-checking bench for tribus_receiver: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a timeline-based model.
module tb_tribus_receiver;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2;
    localparam int D_SETTLE = 1;
    localparam int D_TURN   = 1;

    logic clk;
    logic rst_n;
    logic [W-1:0] drv_data [N];

    // default instance
    logic [N-1:0]  d_req, d_enb;
    logic [W-1:0]  d_bus, d_dout;
    logic [SW-1:0] d_dsrc;
    logic          d_dvalid, d_rdy, d_ferr;
    // SETTLE=3 instance
    logic [N-1:0]  r_req, r_enb;
    logic [W-1:0]  r_bus, r_dout;
    logic [SW-1:0] r_dsrc;
    logic          r_dvalid, r_rdy, r_ferr;
    // TURN=0, SETTLE=2 instance
    logic [N-1:0]  z_req, z_enb;
    logic [W-1:0]  z_bus, z_dout;
    logic [SW-1:0] z_dsrc;
    logic          z_dvalid, z_rdy, z_ferr;

    int vectors;
    int miscompares;

    tribus_receiver #(.N(N), .W(W), .SETTLE(1), .TURN(1)) dut_d (
        .CLK(clk), .RSTB(rst_n), .REQ(d_req), .ENB(d_enb), .BUS(d_bus),
        .DOUT(d_dout), .DSRC(d_dsrc), .DVALID(d_dvalid), .DREADY(d_rdy),
        .FLOAT_ERR(d_ferr));

    tribus_receiver #(.N(N), .W(W), .SETTLE(3), .TURN(1)) dut_r (
        .CLK(clk), .RSTB(rst_n), .REQ(r_req), .ENB(r_enb), .BUS(r_bus),
        .DOUT(r_dout), .DSRC(r_dsrc), .DVALID(r_dvalid), .DREADY(r_rdy),
        .FLOAT_ERR(r_ferr));

    tribus_receiver #(.N(N), .W(W), .SETTLE(2), .TURN(0)) dut_z (
        .CLK(clk), .RSTB(rst_n), .REQ(z_req), .ENB(z_enb), .BUS(z_bus),
        .DOUT(z_dout), .DSRC(z_dsrc), .DVALID(z_dvalid), .DREADY(z_rdy),
        .FLOAT_ERR(z_ferr));

    // Bus models: enabled driver's word, undriven (X) otherwise.
    always_comb begin
        d_bus = 'x;
        for (int i = 0; i < int'(N); i++) if (d_enb[i]) d_bus = drv_data[i];
    end
    always_comb begin
        r_bus = 'x;
        for (int i = 0; i < int'(N); i++) if (r_enb[i]) r_bus = drv_data[i];
    end
    always_comb begin
        z_bus = 'x;
        for (int i = 0; i < int'(N); i++) if (z_enb[i]) z_bus = drv_data[i];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        logic          rdy;
        logic [N-1:0]  enb;
        logic          dvalid;
        logic [W-1:0]  dout;
        logic [SW-1:0] dsrc;
        logic          ferr;
    } vec_t;

    vec_t tbl [13];

    // Reference model: grants are tracked as time stamps on an edge counter.
    int           m_edge, m_next_pick, m_cap_edge, m_ptr, m_owner;
    bit           m_granted;
    logic         m_dvalid, m_ferr;
    logic [W-1:0] m_dout;
    logic [N-1:0] m_enb;
    int           m_dsrc;

    task automatic model_init();
        m_edge = 0; m_next_pick = 0; m_cap_edge = -1; m_ptr = N - 1; m_owner = 0;
        m_granted = 0; m_dvalid = 1'b0; m_ferr = 1'b0; m_dout = '0; m_enb = '0; m_dsrc = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic rdy);
        logic free;
        logic [W-1:0] bv;
        m_edge++;
        free = !m_dvalid || rdy;
        bv = drv_data[m_owner];
        if (m_dvalid && rdy) m_dvalid = 1'b0;
        m_ferr = 1'b0;
        if (m_granted && m_edge == m_cap_edge) begin
            for (int b = 0; b < int'(W); b++) begin
                if (bv[b] !== 1'b0 && bv[b] !== 1'b1) m_ferr = 1'b1;
                else m_dout[b] = bv[b];
            end
            m_dsrc = m_owner; m_dvalid = 1'b1; m_granted = 0;
        end else if (!m_granted && m_edge >= m_next_pick && free && req != '0) begin
            for (int k = 1; k <= int'(N); k++) begin
                if (!m_granted && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_granted = 1;
                end
            end
            m_ptr = m_owner;
            m_cap_edge = m_edge + D_SETTLE;
            m_next_pick = m_edge + D_SETTLE + D_TURN + 1;
        end
        m_enb = m_granted ? (N'(1) << m_owner) : '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_d();
        return 32'({d_enb, d_dvalid, d_dout, d_dsrc, d_ferr});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_req = '0; r_req = '0; z_req = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] fv, fexp;
        logic         fflt;
        vectors = 0;
        miscompares = 0;
        drv_data[0] = 8'h11; drv_data[1] = 8'h22; drv_data[2] = 8'hA5; drv_data[3] = 8'h44;
        d_rdy = 1'b1; r_rdy = 1'b1; z_rdy = 1'b1;
        d_req = '0; r_req = '0; z_req = '0;
        rst_n = 1'b0;

        //                req      rdy   enb      dv    dout   dsrc  ferr
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
        tbl[4]  = '{4'b0011, 1'b0, 4'b0001, 1'b0, 8'hA5, 2'd2, 1'b0};
        tbl[5]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};
        tbl[6]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};
        tbl[7]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 1'b0};
        tbl[9]  = '{4'b0011, 1'b1, 4'b0010, 1'b0, 8'h11, 2'd0, 1'b0};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0};

        // Reset state, before any clock edge.
        #2;
        check("reset_d", pack_d(), 32'd0);
        check("reset_r", 32'({r_enb, r_dvalid, r_dout, r_dsrc, r_ferr}), 32'd0);
        check("reset_z", 32'({z_enb, z_dvalid, z_dout, z_dsrc, z_ferr}), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single request, then backpressure with a held capture.
        for (int i = 0; i < 13; i++) begin
            d_req = tbl[i].req;
            d_rdy = tbl[i].rdy;
            step();
            check($sformatf("table[%0d]", i), pack_d(),
                  32'({tbl[i].enb, tbl[i].dvalid, tbl[i].dout, tbl[i].dsrc, tbl[i].ferr}));
        end

        // Floating low nibble: keeper keeps previous DOUT bits there.
        drv_data[3] = 8'h3C;
        d_rdy = 1'b1;
        d_req = 4'b1000; step();
        d_req = 4'b0000; step();
        check("float_prev", 32'(d_dout), 32'h3C);
        step(); step();
        drv_data[3] = {4'h9, 4'bxxxx};
        fv = drv_data[3];
        fexp = 8'h3C;
        fflt = 1'b0;
        for (int b = 0; b < int'(W); b++) begin
            if (fv[b] !== 1'b0 && fv[b] !== 1'b1) fflt = 1'b1;
            else fexp[b] = fv[b];
        end
        d_req = 4'b1000; step();
        check("float_enb", 32'(d_enb), 32'(4'b1000));
        d_req = 4'b0000; d_rdy = 1'b0; step();
        check("float_capture", pack_d(), 32'({4'b0000, 1'b1, fexp, 2'd3, fflt}));
        step();
        check("float_pulse_end", pack_d(), 32'({4'b0000, 1'b1, fexp, 2'd3, 1'b0}));
        drv_data[3] = 8'h44;
        d_rdy = 1'b1;

        // Round-robin with all requesting: grants every 3 cycles, 0,1,2,3,0.
        do_reset();
        d_req = 4'b1111;
        d_rdy = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            check($sformatf("rr_enb[%0d]", e), 32'(d_enb),
                  ((e - 1) % 3 == 0) ? 32'(N'(1) << (((e - 1) / 3) % 4)) : 32'd0);
        end

        // Randomized run against the model.
        do_reset();
        model_init();
        for (int c = 0; c < 1500; c++) begin
            d_req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) d_req = '0;
            d_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) drv_data[$urandom_range(0, N - 1)] = W'($urandom);
            model_edge(d_req, d_rdy);
            step();
            check("random", pack_d(),
                  32'({m_enb, m_dvalid, m_dout, SW'(m_dsrc), m_ferr}));
        end
        d_req = '0;

        // Reset in the middle of a SETTLE=3 grant.
        do_reset();
        drv_data[0] = 8'h11; drv_data[3] = 8'h44;
        r_rdy = 1'b1;
        r_req = 4'b0100;
        step();
        check("midrst_grant1", 32'(r_enb), 32'(4'b0100));
        r_req = 4'b0000;
        step();
        check("midrst_grant2", 32'(r_enb), 32'(4'b0100));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async", 32'({r_enb, r_dvalid}), 32'd0);
        step();
        check("midrst_held", 32'({r_enb, r_dvalid}), 32'd0);
        rst_n = 1'b1;
        r_req = 4'b1000;
        step();
        check("midrst_first", 32'(r_enb), 32'(4'b1000));
        r_req = 4'b1001;
        step(); step(); step();
        check("midrst_capture", 32'({r_enb, r_dvalid, r_dout, r_dsrc}),
              32'({4'b0000, 1'b1, 8'h44, 2'd3}));
        step();
        check("midrst_turn", 32'(r_enb), 32'd0);
        step();
        check("midrst_next", 32'(r_enb), 32'(4'b0001));
        r_req = '0;

        // TURN=0, SETTLE=2: back-to-back grants with one idle cycle.
        do_reset();
        drv_data[1] = 8'h22;
        z_rdy = 1'b1;
        z_req = 4'b0011;
        for (int e = 1; e <= 6; e++) begin
            logic [N-1:0] ez;
            step();
            ez = (e <= 2) ? 4'b0001 : (e == 3 || e == 6) ? 4'b0000 : 4'b0010;
            check($sformatf("turn0_enb[%0d]", e), 32'(z_enb), 32'(ez));
        end
        check("turn0_data", 32'({z_dvalid, z_dout, z_dsrc}), 32'({1'b1, 8'h22, 2'd1}));
        z_req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
